// File: rtl/ex_alu_pkg.sv
// RV32I_definitions: shared Execute-stage ALU definitions.
//   - `ALU_ADD .. `ALU_PASSB : op encodings as text macros, for legacy decode code
//   - alu_op_t               : the same encodings as a typed enum
//   - shift_mode_t           : mode select for ex_alu_shifter
// Optional feature macro used by ex_alu: ALU_ILLEGAL_CHECK_EN.

`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_AND   4'd2
`define ALU_OR    4'd3
`define ALU_XOR   4'd4
`define ALU_SLL   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_SLT   4'd8
`define ALU_SLTU  4'd9
`define ALU_EQ    4'd10
`define ALU_NE    4'd11
`define ALU_GE    4'd12
`define ALU_GEU   4'd13
`define ALU_PASSB 4'd14

package RV32I_definitions;

    localparam int unsigned XLen = 32;

    typedef enum logic [3:0] {
        AluAdd   = `ALU_ADD,
        AluSub   = `ALU_SUB,
        AluAnd   = `ALU_AND,
        AluOr    = `ALU_OR,
        AluXor   = `ALU_XOR,
        AluSll   = `ALU_SLL,
        AluSrl   = `ALU_SRL,
        AluSra   = `ALU_SRA,
        AluSlt   = `ALU_SLT,
        AluSltu  = `ALU_SLTU,
        AluEq    = `ALU_EQ,
        AluNe    = `ALU_NE,
        AluGe    = `ALU_GE,
        AluGeu   = `ALU_GEU,
        AluPassb = `ALU_PASSB,
        AluRsvd  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        ShiftLeft  = 2'd0,
        ShiftRight = 2'd1,
        ShiftArith = 2'd2
    } shift_mode_t;

endpackage

// File: rtl/ex_alu_shifter.sv
// ex_alu_shifter: 32-bit combinational barrel shifter.
// Ports:
//   data_i  in  32  value to shift
//   amt_i   in   5  shift amount (0 returns data_i unchanged)
//   mode_i  in      left / logical right / arithmetic right
//   data_o  out 32  shifted value

module ex_alu_shifter
    import RV32I_definitions::*;
(
    input  logic [XLen-1:0] data_i,
    input  logic [4:0]      amt_i,
    input  shift_mode_t     mode_i,
    output logic [XLen-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (mode_i)
            ShiftLeft:  data_o = data_i << amt_i;
            ShiftRight: data_o = data_i >> amt_i;
            ShiftArith: data_o = $unsigned($signed(data_i) >>> amt_i);
            default:    data_o = data_i;
        endcase
    end

endmodule

// File: rtl/ex_alu.sv
// ex_alu: RV32I Execute-stage integer ALU with a one-cycle registered copy.
// Ports:
//   clk            in   1  pipeline clock
//   resetn         in   1  synchronous active-low reset of the registered outputs
//   ALU_op         in   4  operation select (alu_op_t encodings)
//   ALU_op1        in  32  operand A
//   ALU_op2        in  32  operand B (only B[4:0] used for shifts)
//   ALU_result     out 32  combinational result
//   ALU_zero       out  1  combinational, result == 0
//   ALU_result_q   out 32  ALU_result registered
//   ALU_zero_q     out  1  ALU_zero registered (resets to 1)
//   ALU_illegal_q  out  1  registered op == 15 flag, only with ALU_ILLEGAL_CHECK_EN

module ex_alu
    import RV32I_definitions::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [3:0]      ALU_op,
    input  logic [XLen-1:0] ALU_op1,
    input  logic [XLen-1:0] ALU_op2,
    output logic [XLen-1:0] ALU_result,
    output logic            ALU_zero,
    output logic [XLen-1:0] ALU_result_q,
    output logic            ALU_zero_q
`ifdef ALU_ILLEGAL_CHECK_EN
    ,
    output logic            ALU_illegal_q
`endif
);

    alu_op_t         op;
    shift_mode_t     shift_mode;
    logic [XLen-1:0] shift_res;
    logic            lt_s;
    logic            lt_u;

    assign op   = alu_op_t'(ALU_op);
    assign lt_s = $signed(ALU_op1) < $signed(ALU_op2);
    assign lt_u = ALU_op1 < ALU_op2;

    always_comb begin
        shift_mode = ShiftLeft;
        case (op)
            AluSrl:  shift_mode = ShiftRight;
            AluSra:  shift_mode = ShiftArith;
            default: shift_mode = ShiftLeft;
        endcase
    end

    ex_alu_shifter u_shifter (
        .data_i (ALU_op1),
        .amt_i  (ALU_op2[4:0]),
        .mode_i (shift_mode),
        .data_o (shift_res)
    );

    always_comb begin
        ALU_result = '0;
        case (op)
            AluAdd:   ALU_result = ALU_op1 + ALU_op2;
            AluSub:   ALU_result = ALU_op1 - ALU_op2;
            AluAnd:   ALU_result = ALU_op1 & ALU_op2;
            AluOr:    ALU_result = ALU_op1 | ALU_op2;
            AluXor:   ALU_result = ALU_op1 ^ ALU_op2;
            AluSll,
            AluSrl,
            AluSra:   ALU_result = shift_res;
            AluSlt:   ALU_result = {31'd0, lt_s};
            AluSltu:  ALU_result = {31'd0, lt_u};
            AluEq:    ALU_result = {31'd0, ALU_op1 == ALU_op2};
            AluNe:    ALU_result = {31'd0, ALU_op1 != ALU_op2};
            AluGe:    ALU_result = {31'd0, ~lt_s};
            AluGeu:   ALU_result = {31'd0, ~lt_u};
            AluPassb: ALU_result = ALU_op2;
            default:  ALU_result = '0;
        endcase
    end

    assign ALU_zero = (ALU_result == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ALU_result_q <= '0;
            ALU_zero_q   <= 1'b1;
        end else begin
            ALU_result_q <= ALU_result;
            ALU_zero_q   <= ALU_zero;
        end
    end

`ifdef ALU_ILLEGAL_CHECK_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ALU_illegal_q <= 1'b0;
        end else begin
            ALU_illegal_q <= (op == AluRsvd);
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu.sv
// Directed self-checking bench for ex_alu.

module tb_ex_alu;

    logic        clk;
    logic        resetn;
    logic [3:0]  ALU_op;
    logic [31:0] ALU_op1;
    logic [31:0] ALU_op2;
    logic [31:0] ALU_result;
    logic        ALU_zero;
    logic [31:0] ALU_result_q;
    logic        ALU_zero_q;
`ifdef ALU_ILLEGAL_CHECK_EN
    logic        ALU_illegal_q;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_alu dut (
        .clk          (clk),
        .resetn       (resetn),
        .ALU_op       (ALU_op),
        .ALU_op1      (ALU_op1),
        .ALU_op2      (ALU_op2),
        .ALU_result   (ALU_result),
        .ALU_zero     (ALU_zero),
        .ALU_result_q (ALU_result_q),
        .ALU_zero_q   (ALU_zero_q)
`ifdef ALU_ILLEGAL_CHECK_EN
        ,
        .ALU_illegal_q(ALU_illegal_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a combinational vector and let it settle.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALU_op  = op;
        ALU_op1 = a;
        ALU_op2 = b;
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        ALU_op  = 4'd0;
        ALU_op1 = 32'd0;
        ALU_op2 = 32'd0;

        // Reset state
        @(posedge clk); #1;
        check("reset_result_q", ALU_result_q, 32'd0);
        check("reset_zero_q", {31'd0, ALU_zero_q}, 32'd1);
`ifdef ALU_ILLEGAL_CHECK_EN
        check("reset_illegal_q", {31'd0, ALU_illegal_q}, 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // Arithmetic
        apply(4'd0, 32'd5, 32'd7);
        check("add_5_7", ALU_result, 32'd12);
        check("add_5_7_zero", {31'd0, ALU_zero}, 32'd0);
        apply(4'd0, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap", ALU_result, 32'd0);
        check("add_wrap_zero", {31'd0, ALU_zero}, 32'd1);
        apply(4'd1, 32'd1, 32'd2);
        check("sub_1_2", ALU_result, 32'hFFFF_FFFF);
        apply(4'd8, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg1_1", ALU_result, 32'd1);
        apply(4'd9, 32'hFFFF_FFFF, 32'd1);
        check("sltu_max_1", ALU_result, 32'd0);

        // Logic
        apply(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and", ALU_result, 32'h00F0_1200);
        apply(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("or", ALU_result, 32'hFFF0_FF34);
        apply(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("xor", ALU_result, 32'hFF00_ED34);

        // Shifts: B[31:5] must be ignored, amount = 1
        apply(4'd6, 32'h8000_0000, 32'h21);
        check("srl", ALU_result, 32'h4000_0000);
        apply(4'd7, 32'h8000_0000, 32'h21);
        check("sra", ALU_result, 32'hC000_0000);
        apply(4'd5, 32'h8000_0000, 32'h21);
        check("sll", ALU_result, 32'd0);
        apply(4'd5, 32'h0000_0003, 32'd4);
        check("sll_4", ALU_result, 32'h0000_0030);
        apply(4'd7, 32'h8765_4321, 32'h20);
        check("sra_amt0", ALU_result, 32'h8765_4321);
        apply(4'd7, 32'h8000_0000, 32'd31);
        check("sra_31", ALU_result, 32'hFFFF_FFFF);

        // Branch compares
        apply(4'd10, 32'd42, 32'd42);
        check("eq_42", ALU_result, 32'd1);
        apply(4'd11, 32'd42, 32'd42);
        check("ne_42", ALU_result, 32'd0);
        apply(4'd12, 32'd42, 32'd42);
        check("ge_42", ALU_result, 32'd1);
        apply(4'd12, 32'hFFFF_FFFE, 32'd2);
        check("ge_neg2_2", ALU_result, 32'd0);
        apply(4'd13, 32'hFFFF_FFFE, 32'd2);
        check("geu_big_2", ALU_result, 32'd1);
        apply(4'd11, 32'd1, 32'd2);
        check("ne_1_2", ALU_result, 32'd1);

        // LUI pass-through
        apply(4'd14, 32'h1111_1111, 32'hABCD_E000);
        check("passb", ALU_result, 32'hABCD_E000);

        // Registered path
        @(negedge clk);
        apply(4'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        check("reg_add_q", ALU_result_q, 32'd7);
        check("reg_add_zero_q", {31'd0, ALU_zero_q}, 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("reg_reset_q", ALU_result_q, 32'd0);
        check("reg_reset_zero_q", {31'd0, ALU_zero_q}, 32'd1);
        check("comb_during_reset", ALU_result, 32'd7);
        @(negedge clk);
        resetn = 1'b1;

        // Reserved op
        apply(4'd15, 32'd9, 32'd9);
        check("rsvd_result", ALU_result, 32'd0);
        check("rsvd_zero", {31'd0, ALU_zero}, 32'd1);
        @(posedge clk); #1;
        check("rsvd_result_q", ALU_result_q, 32'd0);
        check("rsvd_zero_q", {31'd0, ALU_zero_q}, 32'd1);
`ifdef ALU_ILLEGAL_CHECK_EN
        check("rsvd_illegal_q", {31'd0, ALU_illegal_q}, 32'd1);
`endif
        @(negedge clk);
        apply(4'd1, 32'd10, 32'd3);
        @(posedge clk); #1;
        check("sub_q", ALU_result_q, 32'd7);
`ifdef ALU_ILLEGAL_CHECK_EN
        check("legal_illegal_q", {31'd0, ALU_illegal_q}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
